// File: rtl/imem_loader.sv
// Boot loader: streams program words into instruction memory, holds the core in
// reset until the last word is committed, then times the run until core_done.
module imem_loader #(
  parameter int DEPTH     = 1024,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 core_rst,
  input  logic                 core_done,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 finished,
  output logic                 overflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam logic [AW-1:0]        IDX_ONE  = AW'(1);
  localparam logic [AW-1:0]        IDX_LAST = AW'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]           r_state;
  logic [AW-1:0]        r_idx;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic                 r_core_rst;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic                 r_finished;
  logic                 r_overflow;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_at_end;

  assign w_ready  = (r_state == S_LOAD) && !rst;
  assign w_accept = in_valid && w_ready;
  assign w_at_end = (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_LOAD;
      r_idx         <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_core_rst    <= 1'b1;
      r_cycle_count <= '0;
      r_finished    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= 32'({r_idx, 2'b00});
            r_mem_wdata <= in_data;
            r_idx       <= r_idx + IDX_ONE;
            if (in_last || w_at_end) begin
              r_state <= S_RELEASE;
            end
            // Capacity reached before the stream ended: the tail is dropped.
            if (w_at_end && !in_last) begin
              r_overflow <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          r_state    <= S_RUN;
          r_core_rst <= 1'b0;
        end
        S_RUN: begin
          if (r_cycle_count != '1) begin
            r_cycle_count <= r_cycle_count + CNT_ONE;
          end
          if (core_done) begin
            r_state    <= S_HALT;
            r_core_rst <= 1'b1;
            r_finished <= 1'b1;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign in_ready    = w_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign core_rst    = r_core_rst;
  assign cycle_count = r_cycle_count;
  assign finished    = r_finished;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: a full-size loader for load/run/reset scenarios and a tiny
// one (DEPTH=4, 4-bit counter) for overflow and counter saturation.
module tb_imem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst, in_valid, in_last, core_done;
  logic [31:0] in_data;
  logic        in_ready, mem_we, core_rst, finished, overflow;
  logic [31:0] mem_addr, mem_wdata, cycle_count;

  // Instance B: DEPTH=4, CNT_WIDTH=4
  logic        rst_b, in_valid_b, in_last_b, core_done_b;
  logic [31:0] in_data_b;
  logic        in_ready_b, mem_we_b, core_rst_b, finished_b, overflow_b;
  logic [31:0] mem_addr_b, mem_wdata_b;
  logic [3:0]  cycle_count_b;

  imem_loader u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
    .core_done(core_done), .cycle_count(cycle_count), .finished(finished),
    .overflow(overflow)
  );

  imem_loader #(.DEPTH(4), .CNT_WIDTH(4)) u_dut_small (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_last(in_last_b), .in_ready(in_ready_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .core_rst(core_rst_b),
    .core_done(core_done_b), .cycle_count(cycle_count_b),
    .finished(finished_b), .overflow(overflow_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [4];
  logic [31:0] word_q;
  int          n_wr;

  initial begin
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113; prog[3] = 32'h0000_0063;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; core_done = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; in_last_b = 1'b0; core_done_b = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Normal back-to-back load of 4 words
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = prog[i]; in_last = (i == 3);
      tick();
      $display("load word %0d: we=%0b addr=%h data=%h", i, mem_we, mem_addr, mem_wdata);
      chk("load_we", 32'(mem_we), 32'd1);
      chk("load_addr", mem_addr, 32'(i * 4));
      chk("load_wdata", mem_wdata, prog[i]);
    end
    chk("release_core_rst", 32'(core_rst), 32'd1);
    chk("release_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("run_core_rst", 32'(core_rst), 32'd0);
    chk("run_mem_we", 32'(mem_we), 32'd0);
    chk("run_overflow", 32'(overflow), 32'd0);
    chk("run_count_start", cycle_count, 32'd0);

    // Count 10 RUN cycles, core_done on the 10th
    repeat (9) tick();
    chk("run_count_9", cycle_count, 32'd9);
    chk("run_not_finished", 32'(finished), 32'd0);
    core_done = 1'b1;
    tick();
    $display("halt: finished=%0b count=%0d core_rst=%0b", finished, cycle_count, core_rst);
    chk("halt_finished", 32'(finished), 32'd1);
    chk("halt_count", cycle_count, 32'd10);
    chk("halt_core_rst", 32'(core_rst), 32'd1);
    core_done = 1'b0; tick();
    core_done = 1'b1; tick();
    core_done = 1'b0; tick();
    chk("halt_count_held", cycle_count, 32'd10);
    chk("halt_finished_held", 32'(finished), 32'd1);
    chk("halt_core_rst_held", 32'(core_rst), 32'd1);
    chk("halt_in_ready", 32'(in_ready), 32'd0);

    // Reset out of HALT, then a load with bubbles
    rst = 1'b1; tick();
    chk("rst2_finished", 32'(finished), 32'd0);
    chk("rst2_count", cycle_count, 32'd0);
    chk("rst2_core_rst", 32'(core_rst), 32'd1);
    rst = 1'b0;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      word_q = 32'hA000_0000 + 32'(i);
      in_data = word_q;
      in_last = (i == 4);
      tick();
      $display("bubble step %0d: valid=%0b we=%0b addr=%h", i, in_valid, mem_we, mem_addr);
      chk("bubble_we", 32'(mem_we), 32'(in_valid));
      if (in_valid) begin
        chk("bubble_addr", mem_addr, 32'(n_wr * 4));
        chk("bubble_wdata", mem_wdata, word_q);
        n_wr++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("bubble_run_core_rst", 32'(core_rst), 32'd0);
    chk("bubble_run_we", 32'(mem_we), 32'd0);

    // Reset in RUN cycle 5
    repeat (4) tick();
    chk("midrun_count", cycle_count, 32'd4);
    rst = 1'b1;
    #1;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrun_core_rst", 32'(core_rst), 32'd1);
    chk("midrun_count_clr", cycle_count, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrun_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hB000_0000 + 32'(i); in_last = (i == 1);
      tick();
      $display("reload word %0d: we=%0b addr=%h", i, mem_we, mem_addr);
      chk("reload_we", 32'(mem_we), 32'd1);
      chk("reload_addr", mem_addr, 32'(i * 4));
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("reload_run_core_rst", 32'(core_rst), 32'd0);

    // rst coincident with a last word: nothing is accepted
    rst = 1'b1; tick();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    tick();
    $display("rst+last: we=%0b core_rst=%0b", mem_we, core_rst);
    chk("simul_no_we", 32'(mem_we), 32'd0);
    chk("simul_core_rst", 32'(core_rst), 32'd1);
    rst = 1'b0;
    in_data = 32'h1234_5678;
    tick();
    chk("simul_reload_we", 32'(mem_we), 32'd1);
    chk("simul_reload_addr", mem_addr, 32'd0);
    chk("simul_reload_wdata", mem_wdata, 32'h1234_5678);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("simul_run_core_rst", 32'(core_rst), 32'd0);

    // Overflow on DEPTH=4: six words, no last
    rst_b = 1'b0;
    #1;
    chk("ovf_in_ready_start", 32'(in_ready_b), 32'd1);
    for (int i = 0; i < 6; i++) begin
      in_valid_b = 1'b1; in_data_b = 32'hC000_0000 + 32'(i); in_last_b = 1'b0;
      tick();
      $display("overflow step %0d: we=%0b addr=%h ready=%0b ovf=%0b", i, mem_we_b, mem_addr_b, in_ready_b, overflow_b);
      if (i < 4) begin
        chk("ovf_we", 32'(mem_we_b), 32'd1);
        chk("ovf_addr", mem_addr_b, 32'(i * 4));
        chk("ovf_wdata", mem_wdata_b, 32'hC000_0000 + 32'(i));
      end else begin
        chk("ovf_no_extra_we", 32'(mem_we_b), 32'd0);
      end
      if (i == 3) begin
        chk("ovf_in_ready", 32'(in_ready_b), 32'd0);
        chk("ovf_flag", 32'(overflow_b), 32'd1);
        chk("ovf_release_core_rst", 32'(core_rst_b), 32'd1);
      end
      if (i == 4) chk("ovf_run_core_rst", 32'(core_rst_b), 32'd0);
    end
    in_valid_b = 1'b0;

    // 4-bit counter saturates at 15 over ~20 RUN cycles
    repeat (20) tick();
    chk("sat_count", 32'(cycle_count_b), 32'd15);
    chk("sat_overflow_sticky", 32'(overflow_b), 32'd1);
    core_done_b = 1'b1;
    tick();
    chk("sat_finished", 32'(finished_b), 32'd1);
    chk("sat_count_final", 32'(cycle_count_b), 32'd15);
    core_done_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time front end for the single-cycle RISC-V core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes the words sequentially into instruction memory from byte address 0. It holds the core in reset until the last word is committed, then releases it. It counts core cycles until the core raises `done`, and then re-asserts the core's reset to freeze it.

## Interface

Parameters:
- `DEPTH`, 1024: instruction memory capacity in 32-bit words; must be a power of two, ≥ 2.
- `CNT_WIDTH`, 32: width of the cycle counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: program word is available.
- `in_data` input 32: program word.
- `in_last` input 1: marks the final word of the program; qualified by `in_valid`.
- `in_ready` output 1: loader accepts a word this cycle.
- `mem_we` output 1: instruction memory write enable; registered.
- `mem_addr` output 32: byte address of the write, equal to word index × 4; registered.
- `mem_wdata` output 32: write data; registered.
- `core_rst` output 1: reset to the core; registered.
- `core_done` input 1: `done` from the core.
- `cycle_count` output CNT_WIDTH: number of core run cycles.
- `finished` output 1: the core has halted and `cycle_count` is final.
- `overflow` output 1: the program was truncated at `DEPTH` words.

## Operation

- States: LOAD, RELEASE, RUN, HALT.
- A word is accepted when `in_valid && in_ready`.
- `in_ready = (state == LOAD) && !rst`. It is combinational from state only and never depends on `in_valid`.
- LOAD, word accepted:
  - Next cycle: `mem_we=1`, `mem_addr=idx*4`, `mem_wdata=in_data`.
  - `idx` increments by 1.
  - In any cycle with no accept, `mem_we=0`.
- LOAD → RELEASE when any of the following is accepted:
  - a word with `in_last=1`;
  - the word at `idx == DEPTH-1`, regardless of `in_last`.
- Overflow: if the word at `idx == DEPTH-1` is accepted with `in_last=0`, `overflow` is set in the transition cycle. It is sticky until `rst`. The remaining stream is never accepted, because `in_ready=0`.
- RELEASE:
  - Lasts exactly one cycle; the final `mem_we` pulse occurs here.
  - `core_rst` stays 1.
  - Next state is RUN.
- RUN:
  - `core_rst=0`.
  - `cycle_count` increments by 1 on every cycle spent in RUN, including the cycle in which `core_done` is sampled high.
  - `cycle_count` saturates at all-ones and never wraps.
- RUN → HALT when `core_done=1` is sampled.
- HALT:
  - `core_rst=1`, which freezes the core.
  - `finished=1`.
  - `cycle_count` is held.
  - The only exit is `rst`.
- `core_done` is ignored in LOAD, RELEASE and HALT.
- `in_valid`, `in_data` and `in_last` are ignored outside LOAD.
- Zero-length programs do not exist: the first accepted word with `in_last=1` loads a 1-word program.

## Timing

- Reset values, applied in the cycle after `rst` is sampled high:
  - state = LOAD, `idx = 0`.
  - `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `core_rst=1`, `cycle_count=0`, `finished=0`, `overflow=0`.
- `in_ready` is 0 while `rst` is high and 1 in the first cycle after reset.
- Throughput: one word per cycle in LOAD.
- Write latency: a word accepted in cycle t is written with `mem_we=1` in cycle t+1.
- Release sequence when the last word is accepted in cycle t:
  - cycle t+1: RELEASE, last write performed;
  - cycle t+2: RUN, `core_rst=0`; the core fetches from address 0 on the next edge.
- Halt sequence when `core_done=1` is sampled in RUN at cycle u:
  - from cycle u+1: `finished=1` and `core_rst=1`;
  - `cycle_count` = number of RUN cycles, inclusive of u.
- Reset mid-operation, in any state: all state and outputs return to their reset values on the next edge. Memory contents are not cleared; the next load overwrites them from address 0.
- `rst` has priority over every simultaneous event: an accept, `core_done`, or a state transition.

## Test plan

- Normal load: 4 words 0x00000013, 0x00100093, 0x00200113, 0x00000063 sent back-to-back, `in_last` on the 4th → writes at addresses 0, 4, 8, 12 in consecutive cycles; `core_rst` falls 2 cycles after the 4th accept; `overflow=0`.
- Bubbles: `in_valid` toggled 1,0,1,0,1 with `in_last` on the third accepted word → exactly 3 `mem_we` pulses at addresses 0, 4, 8; no write in bubble cycles.
- Cycle count: after load, drive `core_done=1` on the 10th RUN cycle → `finished=1` one cycle later; `cycle_count=10` and held; `core_rst=1`; later `core_done` activity has no effect.
- Overflow with `DEPTH=4`: stream 6 words with no `in_last` → 4 writes at addresses 0 to 12; `in_ready=0` after the 4th accept; `overflow=1`; the core is released normally.
- Reset mid-RUN: assert `rst` for 1 cycle at RUN cycle 5 → next cycle LOAD, `core_rst=1`, `cycle_count=0`, `in_ready=1`; a reload of 2 words writes at addresses 0 and 4.
- Simultaneous events: `rst` high in the same cycle as an accepted `in_last` word → no `mem_we` pulse the following cycle; state LOAD, `idx=0`.
